// File: rtl/reset_ctrl.sv
// System reset controller: sequences dm_rst_n / ndm_rst_n from POR, PLL lock, debug, software
// and pushbutton sources. Define RESET_CTRL_USR_BUTTON_EN to enable the debounced usr_rst_n path.
module reset_ctrl #(
   parameter int unsigned RESET_CYCLES    = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pll_locked,
   input  logic        ndm_reset_req,
   input  logic        usr_rst_n,
   input  logic        wb_adr,
   input  logic [31:0] wb_dat_w,
   input  logic [3:0]  wb_sel,
   input  logic        wb_we,
   input  logic        wb_cyc,
   input  logic        wb_stb,
   output logic [31:0] wb_dat_r,
   output logic        wb_ack,
   output logic        wb_stall,
   output logic        wb_err,
   output logic        dm_rst_n,
   output logic        ndm_rst_n
);
   localparam logic [7:0] RstLoad = 8'(RESET_CYCLES);

   typedef enum logic [1:0] {StPwr, StHoldAll, StHoldNdm, StRun} state_e;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        dm_rst_q, dm_rst_d;
   logic        ndm_rst_q, ndm_rst_d;
   logic [1:0]  pll_sync_q, pll_sync_d;
   logic        pll_ok;
   logic        sw_ndm_q, sw_ndm_d;
   logic        sw_full_q, sw_full_d;
   logic        ack_q, ack_d;
   logic [31:0] dat_r_q, dat_r_d;
   logic [5:0]  reason_q, reason_d;
   logic [5:0]  reason_set, reason_clr;
   logic        usr_press;
   logic        wb_req, wr_ctrl, wr_reason, rd_reason;
   logic        ndm_src, active;
   logic        unused_wb;

   assign pll_ok    = pll_sync_q[1];
   assign unused_wb = ^{wb_dat_w[31:6], wb_sel[3:1]};

   always_comb begin
      pll_sync_d = {pll_sync_q[0], pll_locked};
      wb_req     = wb_cyc & wb_stb;
      wr_ctrl    = wb_req & wb_we & ~wb_adr & wb_sel[0];
      wr_reason  = wb_req & wb_we & wb_adr & wb_sel[0];
      rd_reason  = wb_req & ~wb_we & wb_adr;
      sw_ndm_d   = wr_ctrl & wb_dat_w[0];
      sw_full_d  = wr_ctrl & wb_dat_w[1];
      ack_d      = wb_req;
      dat_r_d    = rd_reason ? {26'd0, reason_q} : 32'd0;
   end

   // Priority: PLL loss > software full > user press > NDM sources.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ndm_src = ndm_reset_req | sw_ndm_q;
      if (state_q == StPwr) begin
         if (pll_ok) begin
            state_d = StHoldAll;
            cnt_d   = RstLoad;
         end
      end else if (!pll_ok) begin
         state_d = StPwr;
         cnt_d   = RstLoad;
      end else if (sw_full_q || usr_press) begin
         state_d = StHoldAll;
         cnt_d   = RstLoad;
      end else if (ndm_src && (state_q == StRun || state_q == StHoldNdm)) begin
         state_d = StHoldNdm;
         cnt_d   = RstLoad;
      end else if (state_q != StRun) begin
         if (cnt_q == 8'd0) begin
            state_d = StRun;
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
      end
      dm_rst_d  = (state_d == StHoldNdm) || (state_d == StRun);
      ndm_rst_d = (state_d == StRun);
   end

   // Sources are only logged once the PLL sequence has left PWR; set wins over W1C.
   always_comb begin
      active     = (state_q != StPwr);
      reason_set = {usr_press, sw_full_q, sw_ndm_q, ndm_reset_req, ~pll_ok, 1'b0} & {6{active}};
      reason_clr = wr_reason ? wb_dat_w[5:0] : 6'd0;
      reason_d   = (reason_q & ~reason_clr) | reason_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StPwr;
         cnt_q      <= RstLoad;
         dm_rst_q   <= 1'b0;
         ndm_rst_q  <= 1'b0;
         pll_sync_q <= 2'b00;
         sw_ndm_q   <= 1'b0;
         sw_full_q  <= 1'b0;
         ack_q      <= 1'b0;
         dat_r_q    <= 32'd0;
         reason_q   <= 6'h01;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dm_rst_q   <= dm_rst_d;
         ndm_rst_q  <= ndm_rst_d;
         pll_sync_q <= pll_sync_d;
         sw_ndm_q   <= sw_ndm_d;
         sw_full_q  <= sw_full_d;
         ack_q      <= ack_d;
         dat_r_q    <= dat_r_d;
         reason_q   <= reason_d;
      end
   end

`ifdef RESET_CTRL_USR_BUTTON_EN
   localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]     usr_sync_q, usr_sync_d;
   logic           usr_lvl_q, usr_lvl_d;
   logic [DbW-1:0] db_cnt_q, db_cnt_d;
   logic           usr_press_q, usr_press_d;

   // The debounced level only flips after DEBOUNCE_CYCLES consecutive samples at the new level.
   always_comb begin
      usr_sync_d  = {usr_sync_q[0], usr_rst_n};
      usr_lvl_d   = usr_lvl_q;
      db_cnt_d    = '0;
      usr_press_d = 1'b0;
      if (usr_sync_q[1] != usr_lvl_q) begin
         if (db_cnt_q == DbLast) begin
            usr_lvl_d   = usr_sync_q[1];
            usr_press_d = ~usr_sync_q[1];
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         usr_sync_q  <= 2'b11;
         usr_lvl_q   <= 1'b1;
         db_cnt_q    <= '0;
         usr_press_q <= 1'b0;
      end else begin
         usr_sync_q  <= usr_sync_d;
         usr_lvl_q   <= usr_lvl_d;
         db_cnt_q    <= db_cnt_d;
         usr_press_q <= usr_press_d;
      end
   end

   assign usr_press = usr_press_q;
`else
   logic unused_usr;
   assign unused_usr = usr_rst_n;
   assign usr_press  = 1'b0;
`endif

   assign dm_rst_n  = dm_rst_q;
   assign ndm_rst_n = ndm_rst_q;
   assign wb_ack    = ack_q;
   assign wb_dat_r  = dat_r_q;
   assign wb_stall  = 1'b0;
   assign wb_err    = 1'b0;

endmodule

// File: tb/tb_reset_ctrl.sv
// Self-checking bench for reset_ctrl: randomized reset sources checked against event-timing
// rules and a sticky REASON model.
module tb_reset_ctrl;
   localparam int unsigned RstCyc = 16;
   localparam int unsigned DbCyc  = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pll_locked = 1'b1;
   logic        ndm_reset_req = 1'b0;
   logic        usr_rst_n = 1'b1;
   logic        wb_adr = 1'b0;
   logic [31:0] wb_dat_w = 32'd0;
   logic [3:0]  wb_sel = 4'd0;
   logic        wb_we = 1'b0;
   logic        wb_cyc = 1'b0;
   logic        wb_stb = 1'b0;
   logic [31:0] wb_dat_r;
   logic        wb_ack, wb_stall, wb_err, dm_rst_n, ndm_rst_n;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [31:0] exp_reason = 32'h1;

   int          dm_falls = 0, ndm_falls = 0;
   int          dm_fall_c = -1, ndm_fall_c = -1, dm_rise_c = -1, ndm_rise_c = -1;
   logic        dm_prev = 1'b0, ndm_prev = 1'b0;

   reset_ctrl #(
      .RESET_CYCLES   (RstCyc),
      .DEBOUNCE_CYCLES(DbCyc)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pll_locked   (pll_locked),
      .ndm_reset_req(ndm_reset_req),
      .usr_rst_n    (usr_rst_n),
      .wb_adr       (wb_adr),
      .wb_dat_w     (wb_dat_w),
      .wb_sel       (wb_sel),
      .wb_we        (wb_we),
      .wb_cyc       (wb_cyc),
      .wb_stb       (wb_stb),
      .wb_dat_r     (wb_dat_r),
      .wb_ack       (wb_ack),
      .wb_stall     (wb_stall),
      .wb_err       (wb_err),
      .dm_rst_n     (dm_rst_n),
      .ndm_rst_n    (ndm_rst_n)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Edge log: the cycle index of the most recent fall/rise of each output.
   always @(negedge clk) begin
      if (dm_prev === 1'b1 && dm_rst_n === 1'b0) begin dm_falls++; dm_fall_c = cyc; end
      if (dm_prev !== 1'b1 && dm_rst_n === 1'b1) dm_rise_c = cyc;
      if (ndm_prev === 1'b1 && ndm_rst_n === 1'b0) begin ndm_falls++; ndm_fall_c = cyc; end
      if (ndm_prev !== 1'b1 && ndm_rst_n === 1'b1) ndm_rise_c = cyc;
      dm_prev  = dm_rst_n;
      ndm_prev = ndm_rst_n;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_run(input int budget);
      int n = 0;
      while (!(dm_rst_n === 1'b1 && ndm_rst_n === 1'b1) && n < budget) begin
         step();
         n++;
      end
      check_eq("run_reached", 32'(dm_rst_n & ndm_rst_n), 32'd1);
      @(negedge clk);
      #1;
   endtask

   task automatic wb_write(input logic adr, input logic [31:0] data, input logic [3:0] sel);
      wb_adr = adr; wb_dat_w = data; wb_sel = sel; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
      step();
      check_eq("wr_ack", 32'(wb_ack), 32'd1);
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
   endtask

   task automatic wb_read(input logic adr, output logic [31:0] data);
      wb_adr = adr; wb_sel = 4'hf; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
      step();
      check_eq("rd_ack", 32'(wb_ack), 32'd1);
      check_eq("rd_stall_err", 32'({wb_stall, wb_err}), 32'd0);
      data = wb_dat_r;
      wb_cyc = 1'b0; wb_stb = 1'b0;
      step();
      check_eq("rd_ack_drop", 32'(wb_ack), 32'd0);
      check_eq("rd_dat_idle", wb_dat_r, 32'd0);
   endtask

   task automatic check_reason(input string tag);
      logic [31:0] rd;
      wb_read(1'b1, rd);
      check_eq(tag, rd, exp_reason);
   endtask

   // Request held for len cycles from n0: ndm low at n0+1, rises RstCyc+1 after the source clears.
   task automatic do_ndm_pulse(input int len);
      int n0 = cyc;
      int d0 = dm_falls;
      ndm_reset_req = 1'b1;
      repeat (len) step();
      ndm_reset_req = 1'b0;
      repeat (4) step();
      wait_run(200);
      check_eq("ndm_fall", ndm_fall_c, n0 + 1);
      check_eq("ndm_rise", ndm_rise_c, n0 + len + RstCyc + 1);
      check_eq("ndm_dm_kept", dm_falls, d0);
      exp_reason |= 32'h04;
   endtask

   // 2 sync flops + output register on loss; on relock 2 sync + load cycle + RstCyc + 1.
   task automatic do_pll_drop(input int len);
      int n0 = cyc;
      int m0;
      pll_locked = 1'b0;
      repeat (len) step();
      m0 = cyc;
      pll_locked = 1'b1;
      repeat (4) step();
      wait_run(200);
      check_eq("pll_dm_fall", dm_fall_c, n0 + 3);
      check_eq("pll_ndm_fall", ndm_fall_c, n0 + 3);
      check_eq("pll_dm_rise", dm_rise_c, m0 + RstCyc + 4);
      check_eq("pll_ndm_rise", ndm_rise_c, m0 + RstCyc + 4);
      exp_reason |= 32'h02;
   endtask

   task automatic do_sw_write(input logic [1:0] bits, input logic [3:0] sel);
      int          n0 = cyc;
      int          d0 = dm_falls;
      int          nd0 = ndm_falls;
      logic [31:0] data = $urandom;
      data[1:0] = bits;
      wb_write(1'b0, data, sel);
      if (sel[0] && bits != 2'b00) begin
         repeat (4) step();
         wait_run(200);
         check_eq("sw_ndm_fall", ndm_fall_c, n0 + 2);
         check_eq("sw_ndm_rise", ndm_rise_c, n0 + RstCyc + 3);
         if (bits[1]) begin
            check_eq("sw_dm_fall", dm_fall_c, n0 + 2);
            check_eq("sw_dm_rise", dm_rise_c, n0 + RstCyc + 3);
         end else begin
            check_eq("sw_dm_kept", dm_falls, d0);
         end
         if (bits[0]) exp_reason |= 32'h08;
         if (bits[1]) exp_reason |= 32'h10;
      end else begin
         repeat (6) step();
         check_eq("sw_nolane_dm", dm_falls, d0);
         check_eq("sw_nolane_ndm", ndm_falls, nd0);
      end
   endtask

   task automatic do_w1c(input logic [31:0] data, input logic [3:0] sel);
      wb_write(1'b1, data, sel);
      if (sel[0]) exp_reason &= ~{26'd0, data[5:0]};
      check_reason("w1c_reason");
   endtask

   initial begin
      logic [31:0] rd;
      logic [3:0]  sel;
      int          k, n0, d0, nd0;

      repeat (3) step();
      check_eq("rst_dm", 32'(dm_rst_n), 32'd0);
      check_eq("rst_ndm", 32'(ndm_rst_n), 32'd0);
      check_eq("rst_ack", 32'(wb_ack), 32'd0);
      check_eq("rst_dat", wb_dat_r, 32'd0);
      check_eq("rst_stall_err", 32'({wb_stall, wb_err}), 32'd0);

      // POR: release, 2 sync cycles, load cycle, then RstCyc + 1.
      rst_n = 1'b1;
      k = cyc;
      repeat (4) step();
      wait_run(200);
      check_eq("por_dm_rise", dm_rise_c, k + RstCyc + 4);
      check_eq("por_ndm_rise", ndm_rise_c, k + RstCyc + 4);
      check_reason("por_reason");
      check_eq("ctrl_reads_0_pre", 32'd0, 32'd0 | wb_dat_r);

      do_pll_drop(50);
      check_reason("pll_reason");
      do_ndm_pulse(5);
      do_sw_write(2'b01, 4'h1);
      do_sw_write(2'b10, 4'h1);
      check_reason("sw_reason");
      do_w1c(32'h3f, 4'h1);

      // Software full reset coincident with a debug request in the ack cycle.
      n0 = cyc;
      wb_adr = 1'b0; wb_dat_w = 32'h2; wb_sel = 4'h1; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
      step();
      check_eq("coin_ack", 32'(wb_ack), 32'd1);
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      ndm_reset_req = 1'b1;
      step();
      ndm_reset_req = 1'b0;
      repeat (3) step();
      wait_run(200);
      check_eq("coin_dm_fall", dm_fall_c, n0 + 2);
      check_eq("coin_dm_rise", dm_rise_c, n0 + RstCyc + 3);
      check_eq("coin_ndm_rise", ndm_rise_c, n0 + RstCyc + 3);
      exp_reason |= 32'h14;
      check_reason("coin_reason");

      for (int it = 0; it < 40; it++) begin
         repeat ($urandom_range(0, 4)) step();
         case ($urandom_range(0, 5))
            0: do_ndm_pulse($urandom_range(1, 8));
            1: begin
               sel = 4'($urandom);
               if ($urandom_range(0, 3) != 0) sel[0] = 1'b1;
               do_sw_write(2'($urandom_range(1, 3)), sel);
            end
            2: do_pll_drop($urandom_range(1, 60));
            3: do_w1c($urandom, 4'($urandom));
            4: begin
               wb_read(1'b0, rd);
               check_eq("ctrl_reads_0", rd, 32'd0);
            end
            default: check_reason("rand_reason");
         endcase
      end
      check_reason("rand_final_reason");

      // Reset asserted mid-hold drops both outputs at once and restores reset values.
      wb_write(1'b0, 32'h1, 4'h1);
      repeat (5) step();
      check_eq("midhold_dm_high", 32'(dm_rst_n), 32'd1);
      #5 rst_n = 1'b0;
      #1;
      check_eq("async_dm", 32'(dm_rst_n), 32'd0);
      check_eq("async_ndm", 32'(ndm_rst_n), 32'd0);
      exp_reason = 32'h1;
      repeat (3) step();
      rst_n = 1'b1;
      k = cyc;
      repeat (4) step();
      wait_run(200);
      check_eq("rerst_dm_rise", dm_rise_c, k + RstCyc + 4);
      check_eq("rerst_ndm_rise", ndm_rise_c, k + RstCyc + 4);
      check_reason("rerst_reason");

`ifdef RESET_CTRL_USR_BUTTON_EN
      d0  = dm_falls;
      nd0 = ndm_falls;
      usr_rst_n = 1'b0;
      repeat (5) step();
      usr_rst_n = 1'b1;
      repeat (30) step();
      check_eq("usr_glitch", dm_falls, d0);
      // Long press, short release, long press: only one debounced press.
      usr_rst_n = 1'b0;
      repeat (12) step();
      usr_rst_n = 1'b1;
      repeat (3) step();
      usr_rst_n = 1'b0;
      repeat (12) step();
      usr_rst_n = 1'b1;
      repeat (4) step();
      wait_run(200);
      check_eq("usr_dm_once", dm_falls, d0 + 1);
      check_eq("usr_ndm_once", ndm_falls, nd0 + 1);
      exp_reason |= 32'h20;
      check_reason("usr_reason");
      repeat (20) step();
      usr_rst_n = 1'b0;
      repeat (12) step();
      usr_rst_n = 1'b1;
      repeat (4) step();
      wait_run(200);
      check_eq("usr_second", dm_falls, d0 + 2);
`else
      d0 = dm_falls;
      usr_rst_n = 1'b0;
      repeat (40) step();
      usr_rst_n = 1'b1;
      repeat (5) step();
      check_eq("usr_ignored", dm_falls, d0);
      check_reason("usr_off_reason");
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
